// File: rtl/program_loader.sv
// Streams program bytes into instruction memory: a start/length load request,
// one write per accepted byte, a running checksum and a core stall while loading.
module program_loader #(
  parameter logic [7:0] BASE_ADDRESS = 8'd0
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       start,
  input  logic [7:0] length,
  input  logic [7:0] byteIn,
  input  logic       byteValid,
  output logic       byteReady,
  output logic       writeEnable,
  output logic [7:0] writeAddress,
  output logic [7:0] writeData,
  output logic       cpuHold,
  output logic       busy,
  output logic       done,
  output logic [7:0] checksum
);

  localparam int unsigned CNT_W = 9;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_inc;
  logic [7:0]         r_checksum;
  logic               r_write_enable;
  logic [7:0]         r_write_address;
  logic [7:0]         r_write_data;
  logic               w_accept;
  logic               w_ready;
  logic               w_busy;
  logic               w_done;
  logic               w_begin;

  assign w_count_inc = r_count + CNT_W'(1);

  // Next-state and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_accept     = 1'b0;
    w_begin      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_begin      = 1'b1;
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ready  = 1'b1;
        w_busy   = 1'b1;
        w_accept = byteValid;
        if (byteValid && (w_count_inc == r_target)) begin
          w_next_state = S_FINISH;
        end
      end
      S_FINISH: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Load bookkeeping and the registered memory write port; reset drops any pending write
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_target        <= '0;
      r_count         <= '0;
      r_checksum      <= '0;
      r_write_enable  <= 1'b0;
      r_write_address <= '0;
      r_write_data    <= '0;
    end else begin
      r_write_enable <= w_accept;
      if (w_begin) begin
        r_target   <= (length == 8'd0) ? CNT_W'(256) : CNT_W'(length);
        r_count    <= '0;
        r_checksum <= '0;
      end
      if (w_accept) begin
        r_write_address <= BASE_ADDRESS + r_count[7:0];
        r_write_data    <= byteIn;
        r_count         <= w_count_inc;
        r_checksum      <= r_checksum + byteIn;
      end
    end
  end

  assign byteReady    = w_ready;
  assign busy         = w_busy;
  assign cpuHold      = w_busy;
  assign done         = w_done;
  assign writeEnable  = r_write_enable;
  assign writeAddress = r_write_address;
  assign writeData    = r_write_data;
  assign checksum     = r_checksum;

endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed bench for program_loader; two instances (base 0 and
// base FE) share stimulus and are checked against a load-level reference model.
module tb_program_loader;

  logic       clock;
  logic       resetN;
  logic       start;
  logic [7:0] length;
  logic [7:0] byteIn;
  logic       byteValid;

  logic       rdy0, we0, hold0, busy0, done0;
  logic [7:0] wa0, wd0, cs0;
  logic       rdy1, we1, hold1, busy1, done1;
  logic [7:0] wa1, wd1, cs1;

  int total = 0;
  int bad   = 0;

  program_loader #(.BASE_ADDRESS(8'h00)) dut0 (
    .clock(clock), .resetN(resetN), .start(start), .length(length),
    .byteIn(byteIn), .byteValid(byteValid), .byteReady(rdy0),
    .writeEnable(we0), .writeAddress(wa0), .writeData(wd0),
    .cpuHold(hold0), .busy(busy0), .done(done0), .checksum(cs0)
  );

  program_loader #(.BASE_ADDRESS(8'hFE)) dut1 (
    .clock(clock), .resetN(resetN), .start(start), .length(length),
    .byteIn(byteIn), .byteValid(byteValid), .byteReady(rdy1),
    .writeEnable(we1), .writeAddress(wa1), .writeData(wd1),
    .cpuHold(hold1), .busy(busy1), .done(done1), .checksum(cs1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a load is "remaining bytes to take", then one finish cycle
  bit         m_loading;
  bit         m_finishing;
  int         m_taken;
  int         m_target;
  logic [7:0] m_sum;
  bit         e_we;
  bit         e_chk_ad;
  logic [7:0] e_a0, e_a1, e_d;

  int n_we0, n_we1, n_done0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rs, input bit st, input logic [7:0] ln,
                      input bit v, input logic [7:0] b);
    resetN = rs; start = st; length = ln; byteValid = v; byteIn = b;
    #1;
    check_eq("ready0", 32'(rdy0), 32'(m_loading));
    check_eq("ready1", 32'(rdy1), 32'(m_loading));
    e_chk_ad = 1'b0;
    if (!rs) begin
      m_loading = 0; m_finishing = 0; m_taken = 0; m_sum = 8'h00;
      e_we = 0; e_chk_ad = 1; e_a0 = 8'h00; e_a1 = 8'h00; e_d = 8'h00;
    end else begin
      e_we = 0;
      if (m_finishing) begin
        m_finishing = 0;
      end else if (m_loading) begin
        if (v) begin
          e_we = 1; e_chk_ad = 1;
          e_a0 = 8'((0 + m_taken) % 256);
          e_a1 = 8'((254 + m_taken) % 256);
          e_d  = b;
          m_sum = 8'((int'(m_sum) + int'(b)) % 256);
          m_taken++;
          if (m_taken == m_target) begin
            m_loading = 0; m_finishing = 1;
          end
        end
      end else if (st) begin
        m_loading = 1;
        m_target  = (ln == 8'd0) ? 256 : int'(ln);
        m_taken   = 0;
        m_sum     = 8'h00;
      end
    end
    @(posedge clock);
    #1;
    check_eq("we0", 32'(we0), 32'(e_we));
    check_eq("we1", 32'(we1), 32'(e_we));
    check_eq("busy0", 32'(busy0), 32'(m_loading | m_finishing));
    check_eq("hold0", 32'(hold0), 32'(m_loading | m_finishing));
    check_eq("busy1", 32'(busy1), 32'(m_loading | m_finishing));
    check_eq("hold1", 32'(hold1), 32'(m_loading | m_finishing));
    check_eq("done0", 32'(done0), 32'(m_finishing));
    check_eq("done1", 32'(done1), 32'(m_finishing));
    check_eq("csum0", 32'(cs0), 32'(m_sum));
    check_eq("csum1", 32'(cs1), 32'(m_sum));
    if (e_chk_ad) begin
      check_eq("addr0", 32'(wa0), 32'(e_a0));
      check_eq("addr1", 32'(wa1), 32'(e_a1));
      check_eq("data0", 32'(wd0), 32'(e_d));
      check_eq("data1", 32'(wd1), 32'(e_d));
    end
    if (we0)   n_we0++;
    if (we1)   n_we1++;
    if (done0) n_done0++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic clear_counts();
    n_we0 = 0; n_we1 = 0; n_done0 = 0;
  endtask

  initial begin
    resetN = 0; start = 0; length = 0; byteIn = 0; byteValid = 0;
    m_loading = 0; m_finishing = 0; m_taken = 0; m_target = 1; m_sum = 0;
    e_we = 0; e_chk_ad = 0; e_a0 = 0; e_a1 = 0; e_d = 0;
    clear_counts();

    step(0, 0, 8'h00, 0, 8'h00);
    step(0, 1, 8'h05, 1, 8'hAA);
    idle(2);

    // Three-byte back-to-back load
    clear_counts();
    step(1, 1, 8'd3, 0, 8'h00);
    step(1, 0, 8'h00, 1, 8'h11);
    step(1, 0, 8'h00, 1, 8'h22);
    step(1, 0, 8'h00, 1, 8'h33);
    idle(3);
    check_eq("n3_writes", 32'(n_we0), 32'd3);
    check_eq("n3_done", 32'(n_done0), 32'd1);
    check_eq("n3_csum", 32'(cs0), 32'h66);

    // Source stalls three cycles between bytes
    clear_counts();
    step(1, 1, 8'd2, 0, 8'h00);
    idle(3);
    step(1, 0, 8'h00, 1, 8'h5A);
    idle(3);
    check_eq("stall_busy", 32'(busy0), 32'd1);
    step(1, 0, 8'h00, 1, 8'hC3);
    idle(2);
    check_eq("stall_writes", 32'(n_we0), 32'd2);

    // Full 256-byte load of 8'h01
    clear_counts();
    step(1, 1, 8'd0, 0, 8'h00);
    for (int i = 0; i < 256; i++) step(1, 0, 8'h00, 1, 8'h01);
    idle(2);
    check_eq("full_writes", 32'(n_we0), 32'd256);
    check_eq("full_done", 32'(n_done0), 32'd1);
    check_eq("full_csum", 32'(cs0), 32'h00);

    // Four bytes exercise the FE..01 wrap on the second instance
    clear_counts();
    step(1, 1, 8'd4, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 1, 8'(8'h40 + i));
    idle(2);
    check_eq("wrap_writes", 32'(n_we1), 32'd4);

    // Reset after two of five bytes, then a one-byte load
    clear_counts();
    step(1, 1, 8'd5, 0, 8'h00);
    step(1, 0, 8'h00, 1, 8'h10);
    step(1, 0, 8'h00, 1, 8'h20);
    step(0, 0, 8'h00, 1, 8'h30);
    check_eq("rst_we", 32'(we0), 32'd0);
    check_eq("rst_csum", 32'(cs0), 32'd0);
    step(1, 0, 8'h00, 1, 8'h40);
    step(1, 0, 8'h00, 1, 8'h50);
    check_eq("rst_writes", 32'(n_we0), 32'd2);
    step(1, 1, 8'd1, 0, 8'h00);
    step(1, 0, 8'h00, 1, 8'h77);
    idle(2);
    check_eq("rst_reload_csum", 32'(cs0), 32'h77);

    // Start pulses while busy must not change the load
    clear_counts();
    step(1, 1, 8'd3, 0, 8'h00);
    step(1, 1, 8'd9, 1, 8'h01);
    step(1, 1, 8'd1, 0, 8'h00);
    step(1, 0, 8'h00, 1, 8'h02);
    step(1, 1, 8'd7, 1, 8'h03);
    idle(2);
    check_eq("busy_start_writes", 32'(n_we0), 32'd3);
    check_eq("busy_start_done", 32'(n_done0), 32'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit rs, st, v;
      logic [7:0] ln, b;
      rs = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 3) == 0);
      ln = 8'($urandom_range(1, 12));
      v  = ($urandom_range(0, 2) != 0);
      b  = 8'($urandom);
      step(rs, st, ln, v, b);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
